// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: opcodes, FSM
// states, ALU operations, immediate formats and datapath select codes.
package riscv_ctrl_pkg;

    // Major opcodes (instruction[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // func7 value that selects SUB on an R-type add slot
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ALU A operand selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU B operand selects
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] SRCB_ZERO  = 2'b11;

    // Result bus selects
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_ALU    = 2'b01;
    localparam logic [1:0] RES_MDR    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    // Multicycle FSM states
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXE_R     = 4'd6,
        S_EXE_I     = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_JALR_PC   = 4'd12,
        S_LUI       = 4'd13,
        S_ILLEGAL   = 4'd14
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational instruction-field decoder: picks the ALU operation used by
// the R/I execute states and flags any instruction the FSM cannot run.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic [2:0] aluop,
    output logic       legal
);

    logic [2:0] f3_aluop;
    logic       f3_ok;
    logic       is_sub;

    // Shared func3 -> ALU map for register and immediate arithmetic
    always_comb begin
        f3_aluop = ALU_ADD;
        f3_ok    = 1'b1;
        case (func3)
            3'b000:  f3_aluop = ALU_ADD;
            3'b111:  f3_aluop = ALU_AND;
            3'b110:  f3_aluop = ALU_OR;
            3'b010:  f3_aluop = ALU_SLT;
            3'b100:  f3_aluop = ALU_XOR;
            default: f3_ok    = 1'b0;
        endcase
    end

    assign is_sub = (func7 == F7_ALT) && (func3 == 3'b000);

    // Per-opcode legality; only R-type can turn ADD into SUB
    always_comb begin
        aluop = ALU_ADD;
        legal = 1'b0;
        case (opcode)
            OP_R: begin
                legal = f3_ok && ((func7 == 7'b0000000) || is_sub);
                aluop = is_sub ? ALU_SUB : f3_aluop;
            end
            OP_I: begin
                legal = f3_ok;
                aluop = f3_aluop;
            end
            OP_LOAD, OP_STORE: legal = (func3 == 3'b010);
            OP_BRANCH: legal = (func3 == 3'b000) || (func3 == 3'b001) ||
                               (func3 == 3'b100) || (func3 == 3'b101);
            OP_JAL:  legal = 1'b1;
            OP_JALR: legal = (func3 == 3'b000);
            OP_LUI:  legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle RISC-V control FSM. Outputs are decoded from the current state
// and the IR fields; only the branch PC enable also looks at the ALU flags.
module control_unit
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zer,
    input  logic       neg,
    output logic       pcen,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluop,
    output logic [1:0] resultsrc,
    output logic [2:0] immsrc,
    output logic       illegal_instr
);

    state_t     state;
    logic [2:0] dec_aluop;
    logic       dec_legal;
    logic       take_branch;

    alu_decoder u_alu_decoder (
        .opcode (opcode),
        .func3  (func3),
        .func7  (func7),
        .aluop  (dec_aluop),
        .legal  (dec_legal)
    );

    // Branch condition from the SUB flags: beq, bne, blt, bge
    always_comb begin
        take_branch = 1'b0;
        case (func3)
            3'b000:  take_branch = zer;
            3'b001:  take_branch = ~zer;
            3'b100:  take_branch = neg;
            3'b101:  take_branch = ~neg;
            default: take_branch = 1'b0;
        endcase
    end

    // State register and transitions; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    if (!dec_legal) begin
                        state <= S_ILLEGAL;
                    end else begin
                        case (opcode)
                            OP_R:               state <= S_EXE_R;
                            OP_I:               state <= S_EXE_I;
                            OP_LOAD, OP_STORE:  state <= S_MEM_ADR;
                            OP_BRANCH:          state <= S_BRANCH;
                            OP_JAL:             state <= S_JAL;
                            OP_JALR:            state <= S_JALR;
                            OP_LUI:             state <= S_LUI;
                            default:            state <= S_ILLEGAL;
                        endcase
                    end
                end
                S_MEM_ADR:   state <= (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  state <= S_MEM_WB;
                S_MEM_WB:    state <= S_FETCH;
                S_MEM_WRITE: state <= S_FETCH;
                S_EXE_R:     state <= S_ALU_WB;
                S_EXE_I:     state <= S_ALU_WB;
                S_ALU_WB:    state <= S_FETCH;
                S_BRANCH:    state <= S_FETCH;
                S_JAL:       state <= S_ALU_WB;
                S_JALR:      state <= S_JALR_PC;
                S_JALR_PC:   state <= S_ALU_WB;
                S_LUI:       state <= S_FETCH;
                S_ILLEGAL:   state <= S_FETCH;
                default:     state <= S_FETCH;
            endcase
        end
    end

    // Per-state datapath controls; enables are held low while reset is asserted
    always_comb begin
        pcen          = 1'b0;
        adrsrc        = 1'b0;
        memwrite      = 1'b0;
        irwrite       = 1'b0;
        regwrite      = 1'b0;
        alusrca       = SRCA_PC;
        alusrcb       = SRCB_REGB;
        aluop         = ALU_ADD;
        resultsrc     = RES_ALUOUT;
        immsrc        = IMM_I;
        illegal_instr = 1'b0;
        case (state)
            S_FETCH: begin
                irwrite   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALU;
                pcen      = 1'b1;
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                immsrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEM_ADR: begin
                alusrca = SRCA_REGA;
                alusrcb = SRCB_IMM;
                immsrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEM_READ:  adrsrc = 1'b1;
            S_MEM_WB: begin
                resultsrc = RES_MDR;
                regwrite  = 1'b1;
            end
            S_MEM_WRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            S_EXE_R: begin
                alusrca = SRCA_REGA;
                alusrcb = SRCB_REGB;
                aluop   = dec_aluop;
            end
            S_EXE_I: begin
                alusrca = SRCA_REGA;
                alusrcb = SRCB_IMM;
                aluop   = dec_aluop;
                immsrc  = IMM_I;
            end
            S_ALU_WB: begin
                resultsrc = RES_ALUOUT;
                regwrite  = 1'b1;
            end
            S_BRANCH: begin
                alusrca   = SRCA_REGA;
                alusrcb   = SRCB_REGB;
                aluop     = ALU_SUB;
                resultsrc = RES_ALUOUT;
                pcen      = take_branch;
            end
            S_JAL, S_JALR_PC: begin
                // PC takes the target parked in ALU-out; ALU forms OLDPC+4 for rd
                alusrca   = SRCA_OLDPC;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALUOUT;
                pcen      = 1'b1;
            end
            S_JALR: begin
                alusrca = SRCA_REGA;
                alusrcb = SRCB_IMM;
                immsrc  = IMM_I;
            end
            S_LUI: begin
                immsrc    = IMM_U;
                resultsrc = RES_IMM;
                regwrite  = 1'b1;
            end
            S_ILLEGAL: illegal_instr = 1'b1;
            default: ;
        endcase
        if (!rst) begin
            pcen          = 1'b0;
            memwrite      = 1'b0;
            irwrite       = 1'b0;
            regwrite      = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule
